// File: rtl/week_5_parity_serial_rx.sv
// Serial receiver for start / DATA_W data bits (LSB first) / even parity / stop frames.
// Every bit is sampled mid-period; all outputs are registered.
module week_5_parity_serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t            state_r, state_next;
  logic [CNT_W-1:0]  cnt_r, cnt_next;
  logic [IDX_W-1:0]  idx_r, idx_next;
  logic [DATA_W-1:0] shift_r, shift_next;
  logic              par_r, par_next;
  logic              done_s;

  // Next-state, bit-period counter and data/parity accumulation
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r + CNT_W'(1);
    idx_next   = idx_r;
    shift_next = shift_r;
    par_next   = par_r;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_next = '0;
        if (!rx_in) begin
          state_next = START;
          idx_next   = '0;
          par_next   = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx_in ? IDLE : DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (cnt_r == FULL_LAST) begin
          cnt_next   = '0;
          shift_next = DATA_W'({rx_in, shift_r} >> 1);
          par_next   = par_r ^ rx_in;
          if (idx_r == IDX_LAST) begin
            state_next = PARITY;
          end else begin
            idx_next = idx_r + IDX_W'(1);
          end
        end else begin
          state_next = DATA;
        end
      end
      PARITY: begin
        if (cnt_r == FULL_LAST) begin
          cnt_next   = '0;
          par_next   = par_r ^ rx_in;
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end
      STOP: begin
        if (cnt_r == FULL_LAST) begin
          cnt_next   = '0;
          done_s     = 1'b1;
          state_next = rx_in ? IDLE : WAIT_IDLE;
        end else begin
          state_next = STOP;
        end
      end
      WAIT_IDLE: begin
        // A broken stop bit keeps the receiver parked until the line is released
        cnt_next   = '0;
        state_next = rx_in ? IDLE : WAIT_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; results publish on the stop-sample edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      shift_r    <= '0;
      par_r      <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      idx_r   <= idx_next;
      shift_r <= shift_next;
      par_r   <= par_next;
      valid   <= done_s;
      busy    <= (state_next != IDLE);
      if (done_s) begin
        data_out   <= shift_r;
        parity_err <= par_r;
        frame_err  <= ~rx_in;
      end else begin
        data_out   <= data_out;
        parity_err <= parity_err;
        frame_err  <= frame_err;
      end
    end
  end

endmodule

// File: doc/week_5_parity_serial_rx.md
WEEK_5_PARITY_SERIAL_RX -- requirements
Module: week_5_parity_serial_rx

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit period; SHALL be an even value of at least 2.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port rx_in, input, 1, serial line, idle high, synchronous to clk.
REQ-006 Port data_out, output, DATA_W, last completed frame's data bits.
REQ-007 Port valid, output, 1, one-cycle pulse marking a completed frame.
REQ-008 Port parity_err, output, 1, even-parity check result of last completed frame.
REQ-009 Port frame_err, output, 1, stop-bit check result of last completed frame.
REQ-010 Port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 Frame format SHALL be: start bit 0, DATA_W data bits LSB first, one even-parity bit, one stop bit 1.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-013 IDLE: first edge sampling rx_in=0 is cycle 0; FSM SHALL move to START and clear the bit-period counter.
REQ-014 START: rx_in SHALL be resampled at cycle CLKS_PER_BIT/2.
- 0: go to DATA.
- 1: false start; return to IDLE with no output change.
REQ-015 Data bit i (i=0..DATA_W-1) SHALL be sampled at cycle CLKS_PER_BIT/2 + CLKS_PER_BIT*(i+1).
REQ-016 The parity bit SHALL be sampled CLKS_PER_BIT cycles after the last data bit; the stop bit CLKS_PER_BIT cycles after that.
REQ-017 Parity SHALL be accumulated by XOR of every data bit and the parity bit; a nonzero result is a parity error.
REQ-018 On the edge after the stop sample, all of the following SHALL update together; frame with errors SHALL still pulse valid:
- data_out = shifted data.
- parity_err = XOR result.
- frame_err = NOT stop bit.
- valid = 1 for exactly one cycle.
REQ-019 data_out, parity_err and frame_err SHALL hold until the next completed frame.
REQ-020 After a stop bit of 1 the FSM SHALL return to IDLE and SHALL accept a new start bit on the next cycle.
REQ-021 After a stop bit of 0 the FSM SHALL enter WAIT_IDLE and SHALL ignore rx_in until it samples 1, then go to IDLE.
REQ-022 The bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and wrap to 0 at each sample point; the data-bit index SHALL saturate at DATA_W-1.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from rx_in to any output.

Reset
REQ-024 rst_n=0 SHALL immediately force:
- FSM to IDLE.
- Counters to 0.
- data_out, valid, parity_err, frame_err, busy to 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; no valid pulse SHALL follow.
REQ-026 After rst_n rises, the first start bit SHALL be recognised per REQ-013.

Verification (DATA_W=8, CLKS_PER_BIT=4)
REQ-027 Frame 0xA5, parity 0, stop 1 -> valid pulses one cycle after the cycle-42 sample; data_out=0xA5, parity_err=0, frame_err=0.
REQ-028 Frame 0x01, parity 0, stop 1 -> valid pulses, data_out=0x01, parity_err=1, frame_err=0.
REQ-029 Frame 0x3C, parity 0, stop 0, line held low 20 more cycles -> valid pulses, frame_err=1, busy stays 1 until rx_in returns high; no new frame starts meanwhile.
REQ-030 rx_in low for one cycle, then high -> busy high for cycles 1-2 only; no valid; outputs unchanged.
REQ-031 rst_n pulsed low during data bit 3 -> all outputs 0 at once, no valid; next frame 0xFF, parity 0 -> data_out=0xFF, no errors.
REQ-032 Frames 0x00 then 0x81, each parity 0, one idle bit between -> two valid pulses 48 cycles apart; data_out=0x00 then 0x81, no errors.
